// File: rtl/regfile_pkg.sv
// Shared defaults for the RV32IM integer register file with pending-write scoreboard.
// Build option REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
package regfile_pkg;

    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_ADDR_W   = 5;
    localparam int DEFAULT_NUM_READ = 2;
    localparam int REG_ZERO         = 0;
    localparam int DEPTH            = 2 ** DEFAULT_ADDR_W;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: address mux, busy lookup and optional forwarding.
// Build option REGFILE_BYPASS_EN adds the write-to-read bypass path.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0] adrs,
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    input  logic [2**ADDR_W-1:0] busy,
`ifdef REGFILE_BYPASS_EN
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] wb_address,
    input  logic [DATA_W-1:0] write_data,
`endif
    output logic [DATA_W-1:0] data,
    output logic              ready
);

    // The hardwired-zero override comes last so forwarding can never leak into x0.
    always_comb begin
        data  = regs[adrs];
        ready = !busy[adrs];
`ifdef REGFILE_BYPASS_EN
        if (write_enable && (wb_address == adrs)) begin
            data  = write_data;
            ready = 1'b1;
        end
`endif
        if ((ZERO_REG != 0) && (adrs == ADDR_W'(REG_ZERO))) begin
            data  = '0;
            ready = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with per-register busy scoreboard, flush and WAW back-pressure.
// Build option REGFILE_BYPASS_EN forwards the writeback value to matching read ports.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NUM_READ = DEFAULT_NUM_READ,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_READ*ADDR_W-1:0] rd_adrs,
    output logic [NUM_READ*DATA_W-1:0] rd_data,
    output logic [NUM_READ-1:0]        rd_ready,
    input  logic                       issue_en,
    input  logic [ADDR_W-1:0]          issue_adrs,
    output logic                       issue_ready,
    input  logic                       write_enable,
    input  logic [ADDR_W-1:0]          wb_address,
    input  logic [DATA_W-1:0]          write_data,
    input  logic                       flush,
    output logic [ADDR_W:0]            busy_count
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int CNT_W    = ADDR_W + 1;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    logic wr_fire;
    logic issue_fire;
    logic cnt_inc;
    logic cnt_dec;

    // Writes and issues aimed at a hardwired x0 are accepted but change nothing.
    assign wr_fire     = write_enable && !((ZERO_REG != 0) && (wb_address == ADDR_W'(REG_ZERO)));
    assign issue_ready = !flush && (!busy[issue_adrs] || (write_enable && (wb_address == issue_adrs)));
    assign issue_fire  = issue_en && issue_ready
                         && !((ZERO_REG != 0) && (issue_adrs == ADDR_W'(REG_ZERO)));

    // Count tracks the real change of busy bits; a write cleared by a same-register issue is no change.
    assign cnt_inc = issue_fire && !busy[issue_adrs];
    assign cnt_dec = wr_fire && busy[wb_address] && !(issue_fire && (issue_adrs == wb_address));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (wr_fire) begin
                regs[wb_address] <= write_data;
            end
            if (flush) begin
                busy       <= '0;
                busy_count <= '0;
            end else begin
                if (wr_fire) begin
                    busy[wb_address] <= 1'b0;
                end
                if (issue_fire) begin
                    busy[issue_adrs] <= 1'b1;
                end
                busy_count <= busy_count + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
            end
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_port
        regfile_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .adrs         (rd_adrs[i*ADDR_W +: ADDR_W]),
            .regs         (regs),
            .busy         (busy),
`ifdef REGFILE_BYPASS_EN
            .write_enable (write_enable),
            .wb_address   (wb_address),
            .write_data   (write_data),
`endif
            .data         (rd_data[i*DATA_W +: DATA_W]),
            .ready        (rd_ready[i])
        );
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard; expected read data flows through a queue.
// Bypass expectations follow REGFILE_BYPASS_EN.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_adrs;
    logic [63:0] rd_data;
    logic [1:0]  rd_ready;
    logic        issue_en;
    logic [4:0]  issue_adrs;
    logic        issue_ready;
    logic        write_enable;
    logic [4:0]  wb_address;
    logic [31:0] write_data;
    logic        flush;
    logic [5:0]  busy_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q [$];
    logic [31:0] exp_d;

    regfile_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .rd_adrs      (rd_adrs),
        .rd_data      (rd_data),
        .rd_ready     (rd_ready),
        .issue_en     (issue_en),
        .issue_adrs   (issue_adrs),
        .issue_ready  (issue_ready),
        .write_enable (write_enable),
        .wb_address   (wb_address),
        .write_data   (write_data),
        .flush        (flush),
        .busy_count   (busy_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input logic [4:0] a);
        rd_adrs[p*5 +: 5] = a;
    endtask

    task automatic idle_inputs;
        issue_en     = 1'b0;
        write_enable = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle_inputs();
        issue_adrs = 5'd0; wb_address = 5'd0; write_data = '0; rd_adrs = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        n_checks++; if (busy_count !== 6'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", busy_count); end
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_issue_ready: got %b expected 1", issue_ready); end
        for (int a = 0; a < 32; a++) begin
            set_rd(0, 5'(a));
            set_rd(1, 5'(31 - a));
            #1;
            n_checks++; if (rd_data !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_data a=%0d: got %h expected 0", a, rd_data); end
            n_checks++; if (rd_ready !== 2'b11) begin n_fail++; $display("[TB] FAIL reset_ready a=%0d: got %b expected 11", a, rd_ready); end
        end
    endtask

    task automatic test_write_read;
        write_enable = 1'b1; wb_address = 5'd2; write_data = 32'h0000000A;
        exp_q.push_back(32'h0000000A);
        tick();
        idle_inputs();
        set_rd(0, 5'd2);
        #1;
        exp_d = exp_q.pop_front();
        n_checks++; if (rd_data[31:0] !== exp_d) begin n_fail++; $display("[TB] FAIL write_read_x2: got %h expected %h", rd_data[31:0], exp_d); end
    endtask

    task automatic test_issue_write;
        issue_en = 1'b1; issue_adrs = 5'd5;
        tick();
        idle_inputs();
        set_rd(0, 5'd5);
        #1;
        n_checks++; if (rd_ready[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL issue_busy_x5: got %b expected 0", rd_ready[0]); end
        n_checks++; if (busy_count !== 6'd1) begin n_fail++; $display("[TB] FAIL issue_count: got %0d expected 1", busy_count); end
        write_enable = 1'b1; wb_address = 5'd5; write_data = 32'h0000000B;
        exp_q.push_back(32'h0000000B);
        tick();
        idle_inputs();
        #1;
        exp_d = exp_q.pop_front();
        n_checks++; if (rd_data[31:0] !== exp_d) begin n_fail++; $display("[TB] FAIL wb_data_x5: got %h expected %h", rd_data[31:0], exp_d); end
        n_checks++; if (rd_ready[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL wb_ready_x5: got %b expected 1", rd_ready[0]); end
        n_checks++; if (busy_count !== 6'd0) begin n_fail++; $display("[TB] FAIL wb_count: got %0d expected 0", busy_count); end
    endtask

    task automatic test_waw;
        issue_en = 1'b1; issue_adrs = 5'd5;
        tick();
        #1;
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL waw_blocked: got %b expected 0", issue_ready); end
        tick();
        n_checks++; if (busy_count !== 6'd1) begin n_fail++; $display("[TB] FAIL waw_count_hold: got %0d expected 1", busy_count); end
        write_enable = 1'b1; wb_address = 5'd5; write_data = 32'h0000000B;
        exp_q.push_back(32'h0000000B);
        #1;
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL waw_accept: got %b expected 1", issue_ready); end
        tick();
        idle_inputs();
        set_rd(0, 5'd5);
        #1;
        exp_d = exp_q.pop_front();
        n_checks++; if (rd_data[31:0] !== exp_d) begin n_fail++; $display("[TB] FAIL waw_data_x5: got %h expected %h", rd_data[31:0], exp_d); end
        n_checks++; if (rd_ready[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL waw_still_busy: got %b expected 0", rd_ready[0]); end
        n_checks++; if (busy_count !== 6'd1) begin n_fail++; $display("[TB] FAIL waw_count: got %0d expected 1", busy_count); end
        write_enable = 1'b1; wb_address = 5'd5; write_data = 32'h0000000B;
        tick();
        idle_inputs();
        #1;
        n_checks++; if (busy_count !== 6'd0) begin n_fail++; $display("[TB] FAIL waw_release_count: got %0d expected 0", busy_count); end
    endtask

    task automatic test_zero_reg;
        write_enable = 1'b1; wb_address = 5'd0; write_data = 32'h0000000C;
        issue_en = 1'b1; issue_adrs = 5'd0;
        exp_q.push_back(32'h0);
        tick();
        idle_inputs();
        set_rd(0, 5'd0); set_rd(1, 5'd0);
        #1;
        exp_d = exp_q.pop_front();
        n_checks++; if (rd_data[31:0] !== exp_d) begin n_fail++; $display("[TB] FAIL zero_data: got %h expected %h", rd_data[31:0], exp_d); end
        n_checks++; if (rd_ready !== 2'b11) begin n_fail++; $display("[TB] FAIL zero_ready: got %b expected 11", rd_ready); end
        n_checks++; if (busy_count !== 6'd0) begin n_fail++; $display("[TB] FAIL zero_count: got %0d expected 0", busy_count); end
    endtask

    task automatic test_flush_reset;
        logic [4:0] targets [3] = '{5'd3, 5'd4, 5'd6};
        foreach (targets[k]) begin
            issue_en = 1'b1; issue_adrs = targets[k];
            tick();
        end
        idle_inputs();
        #1;
        n_checks++; if (busy_count !== 6'd3) begin n_fail++; $display("[TB] FAIL flush_pre_count: got %0d expected 3", busy_count); end
        flush = 1'b1; issue_en = 1'b1; issue_adrs = 5'd8;
        write_enable = 1'b1; wb_address = 5'd7; write_data = 32'h0000000D;
        exp_q.push_back(32'h0000000D);
        #1;
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_issue_blocked: got %b expected 0", issue_ready); end
        tick();
        idle_inputs();
        #1;
        n_checks++; if (busy_count !== 6'd0) begin n_fail++; $display("[TB] FAIL flush_count: got %0d expected 0", busy_count); end
        foreach (targets[k]) begin
            set_rd(1, targets[k]);
            #1;
            n_checks++; if (rd_ready[1] !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_ready x%0d: got %b expected 1", targets[k], rd_ready[1]); end
        end
        set_rd(0, 5'd7); set_rd(1, 5'd8);
        #1;
        exp_d = exp_q.pop_front();
        n_checks++; if (rd_data[31:0] !== exp_d) begin n_fail++; $display("[TB] FAIL flush_write_x7: got %h expected %h", rd_data[31:0], exp_d); end
        n_checks++; if (rd_ready[1] !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_no_issue_x8: got %b expected 1", rd_ready[1]); end
        reset = 1'b1;
        write_enable = 1'b1; wb_address = 5'd11; write_data = 32'h00000055;
        issue_en = 1'b1; issue_adrs = 5'd10;
        tick();
        reset = 1'b0;
        idle_inputs();
        set_rd(0, 5'd11); set_rd(1, 5'd10);
        #1;
        n_checks++; if (rd_data[31:0] !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_discard_x11: got %h expected 0", rd_data[31:0]); end
        n_checks++; if (rd_ready[1] !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_discard_x10: got %b expected 1", rd_ready[1]); end
        n_checks++; if (busy_count !== 6'd0) begin n_fail++; $display("[TB] FAIL reset_mid_count: got %0d expected 0", busy_count); end
        set_rd(0, 5'd7); set_rd(1, 5'd2);
        #1;
        n_checks++; if (rd_data !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_mid_data: got %h expected 0", rd_data); end
    endtask

    task automatic test_bypass;
        issue_en = 1'b1; issue_adrs = 5'd9;
        tick();
        idle_inputs();
        set_rd(0, 5'd9); set_rd(1, 5'd9);
        #1;
        n_checks++; if (rd_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL bypass_pre_busy: got %b expected 00", rd_ready); end
        write_enable = 1'b1; wb_address = 5'd9; write_data = 32'h0000000E;
`ifdef REGFILE_BYPASS_EN
        exp_q.push_back(32'h0000000E);
`else
        exp_q.push_back(32'h0);
`endif
        exp_q.push_back(32'h0000000E);
        #1;
        exp_d = exp_q.pop_front();
        n_checks++; if (rd_data[63:32] !== exp_d) begin n_fail++; $display("[TB] FAIL bypass_same_cycle_data: got %h expected %h", rd_data[63:32], exp_d); end
`ifdef REGFILE_BYPASS_EN
        n_checks++; if (rd_ready[1] !== 1'b1) begin n_fail++; $display("[TB] FAIL bypass_same_cycle_ready: got %b expected 1", rd_ready[1]); end
`else
        n_checks++; if (rd_ready[1] !== 1'b0) begin n_fail++; $display("[TB] FAIL bypass_same_cycle_ready: got %b expected 0", rd_ready[1]); end
`endif
        tick();
        idle_inputs();
        #1;
        exp_d = exp_q.pop_front();
        n_checks++; if (rd_data[63:32] !== exp_d) begin n_fail++; $display("[TB] FAIL bypass_next_data_p1: got %h expected %h", rd_data[63:32], exp_d); end
        n_checks++; if (rd_data[31:0] !== exp_d) begin n_fail++; $display("[TB] FAIL bypass_next_data_p0: got %h expected %h", rd_data[31:0], exp_d); end
        n_checks++; if (rd_ready !== 2'b11) begin n_fail++; $display("[TB] FAIL bypass_next_ready: got %b expected 11", rd_ready); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] val;
        for (int a = 16; a < 24; a++) begin
            val = $urandom;
            write_enable = 1'b1; wb_address = 5'(a); write_data = val;
            exp_q.push_back(val);
            tick();
        end
        idle_inputs();
        for (int a = 16; a < 24; a += 2) begin
            set_rd(0, 5'(a)); set_rd(1, 5'(a + 1));
            #1;
            exp_d = exp_q.pop_front();
            n_checks++; if (rd_data[31:0] !== exp_d) begin n_fail++; $display("[TB] FAIL b2b_p0 x%0d: got %h expected %h", a, rd_data[31:0], exp_d); end
            exp_d = exp_q.pop_front();
            n_checks++; if (rd_data[63:32] !== exp_d) begin n_fail++; $display("[TB] FAIL b2b_p1 x%0d: got %h expected %h", a + 1, rd_data[63:32], exp_d); end
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_issue_write();
        test_waw();
        test_zero_reg();
        test_flush_reset();
        test_bypass();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
